sensor_sampler: RTL

Sequential acquisition stage upstream of the height-to-time path in `baggage_drop`. On request, it samples the four 8-bit distance sensors over `SAMPLES` consecutive clock cycles. Each cycle it applies the pair-validity rule, averages the valid frames, and presents one registered 8-bit `height` with a single-cycle `height_valid` strobe. The strobe tells the square-root and display stages when a fresh, filtered height is available.

---
 rtl/sensor_sampler_if.sv | 38 +++
 rtl/sensor_sampler.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sensor_sampler_if.sv
// Bus bundle between the sensor front end / requester and sensor_sampler.
// The master drives the request and raw sensor readings; the slave (the
// sampler) returns the filtered height and its status.
interface sensor_sampler_if;
  logic       sample_req;
  logic [7:0] sensor1;
  logic [7:0] sensor2;
  logic [7:0] sensor3;
  logic [7:0] sensor4;
  logic [7:0] height;
  logic       height_valid;
  logic       fault;
  logic       busy;

  modport master (
    output sample_req,
    output sensor1,
    output sensor2,
    output sensor3,
    output sensor4,
    input  height,
    input  height_valid,
    input  fault,
    input  busy
  );

  modport slave (
    input  sample_req,
    input  sensor1,
    input  sensor2,
    input  sensor3,
    input  sensor4,
    output height,
    output height_valid,
    output fault,
    output busy
  );
endinterface

// File: rtl/sensor_sampler.sv
// sensor_sampler: on request, averages SAMPLES frames of four distance sensors
// into one registered 8-bit height with a single-cycle completion strobe.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for sample_req; acc/frame_cnt/bad cleared on accept
// ACQ   | one frame consumed per edge; last frame produces the result
module sensor_sampler #(
  parameter int SAMPLES = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  sensor_sampler_if.slave         bus
);

  localparam int SHIFT = $clog2(SAMPLES);
  localparam int ACC_W = 8 + SHIFT;
  localparam int CNT_W = SHIFT;

  typedef enum logic {
    IDLE = 1'b0,
    ACQ  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bad_q, bad_d;
  logic [7:0]         height_q, height_d;
  logic               fault_q, fault_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               pair_a_ok;
  logic               pair_b_ok;
  logic [9:0]         sum_all;
  logic [8:0]         sum_a;
  logic [8:0]         sum_b;
  logic [7:0]         frame_val;
  logic               frame_bad;
  logic [ACC_W-1:0]   acc_sum;
  logic               last_frame;

  // Pair validity: a zero reading means no echo or a faulty sensor.
  assign pair_a_ok = (bus.sensor1 != 8'd0) && (bus.sensor3 != 8'd0);
  assign pair_b_ok = (bus.sensor2 != 8'd0) && (bus.sensor4 != 8'd0);

  // Sums widened so that neither the 4-way nor the pair sum can wrap.
  assign sum_all = {2'b00, bus.sensor1} + {2'b00, bus.sensor2}
                 + {2'b00, bus.sensor3} + {2'b00, bus.sensor4};
  assign sum_a   = {1'b0, bus.sensor1} + {1'b0, bus.sensor3};
  assign sum_b   = {1'b0, bus.sensor2} + {1'b0, bus.sensor4};

  // Per-frame value from the currently presented sensors; shifts truncate.
  always_comb begin
    frame_val = 8'd0;
    frame_bad = 1'b0;
    if (pair_a_ok && pair_b_ok) begin
      frame_val = 8'(sum_all >> 2);
    end else if (pair_a_ok) begin
      frame_val = 8'(sum_a >> 1);
    end else if (pair_b_ok) begin
      frame_val = 8'(sum_b >> 1);
    end else begin
      frame_bad = 1'b1;
    end
  end

  // Accumulator is sized for SAMPLES full-scale frames, so it cannot wrap.
  assign acc_sum    = acc_q + ACC_W'(frame_val);
  assign last_frame = (cnt_q == CNT_W'(SAMPLES - 1));

  // Next-state and datapath updates; the final frame is folded into the result.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    height_d = height_q;
    fault_d  = fault_q;
    valid_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.sample_req) begin
          state_d = ACQ;
          acc_d   = '0;
          cnt_d   = '0;
          bad_d   = 1'b0;
        end
      end
      ACQ: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + CNT_W'(1);
        bad_d = bad_q | frame_bad;
        if (last_frame) begin
          state_d = IDLE;
          valid_d = 1'b1;
          if (bad_q || frame_bad) begin
            fault_d = 1'b1;
          end else begin
            height_d = 8'(acc_sum >> SHIFT);
            fault_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == ACQ);
  end

  // State and output registers; reset discards any measurement in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      height_q <= 8'd0;
      fault_q  <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      bad_q    <= bad_d;
      height_q <= height_d;
      fault_q  <= fault_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.height       = height_q;
  assign bus.height_valid = valid_q;
  assign bus.fault        = fault_q;
  assign bus.busy         = busy_q;

endmodule
